// File: rtl/rom_access_arbiter_pkg.sv
// rom_access_arbiter_pkg
//   Shared definitions for the ROM access arbiter: FSM state encodings,
//   default geometry and the round-robin pointer wrap helper.
package rom_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ADDR_W      = 11;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ID_W        = 2;

    // Pointer to the master after v, wrapping to 0 after n-1.
    function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// rom_access_arbiter_if
//   Bus bundle between the requesting masters, the arbiter and the ROM slave.
//   slave  : arbiter view (takes requests and ROM response, drives grants/ROM strobes)
//   master : environment view (masters + ROM)
//   Signals: m_req_n, m_addr (per master), m_gnt_n, m_rdy_n, m_rd_data,
//            rom_cs_n, rom_as_n, rom_addr, rom_rd_data, rom_rdy_n. All strobes active-low.
interface rom_access_arbiter_if
    import rom_access_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
);
    logic [NUM_MASTERS-1:0]             m_req_n;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0]             m_gnt_n;
    logic [NUM_MASTERS-1:0]             m_rdy_n;
    logic [DATA_W-1:0]                  m_rd_data;
    logic                               rom_cs_n;
    logic                               rom_as_n;
    logic [ADDR_W-1:0]                  rom_addr;
    logic [DATA_W-1:0]                  rom_rd_data;
    logic                               rom_rdy_n;

    modport slave (
        input  m_req_n, m_addr, rom_rd_data, rom_rdy_n,
        output m_gnt_n, m_rdy_n, m_rd_data, rom_cs_n, rom_as_n, rom_addr
    );

    modport master (
        output m_req_n, m_addr, rom_rd_data, rom_rdy_n,
        input  m_gnt_n, m_rdy_n, m_rd_data, rom_cs_n, rom_as_n, rom_addr
    );
endinterface

// File: rtl/rom_access_arbiter_rr_pick.sv
// rr_priority_pick
//   Combinational round-robin picker. Scans masters starting at ptr, wrapping
//   modulo NUM_MASTERS; the first active request wins, except exclude_id when
//   exclude_valid is set.
//   req (active-high), ptr, exclude_valid, exclude_id -> found, winner_id
module rr_priority_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_W-1:0]        ptr,
    input  logic                   exclude_valid,
    input  logic [ID_W-1:0]        exclude_id,
    output logic                   found,
    output logic [ID_W-1:0]        winner_id
);
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        winner_id = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && req[idx] && !(exclude_valid && ID_W'(idx) == exclude_id)) begin
                found     = 1'b1;
                winner_id = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
//   Shares a single-port ROM among NUM_MASTERS masters with round-robin
//   arbitration, one ADDR+RESP access per grant.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : master requests/grants/ready and ROM strobes/response
//   owner_id     : index of the current grant holder
//   busy         : high while in ADDR or RESP
module rom_access_arbiter
    import rom_access_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ID_W        = DEF_ID_W
) (
    input  logic                  clk,
    input  logic                  reset,
    rom_access_arbiter_if.slave   bus,
    output logic [ID_W-1:0]       owner_id,
    output logic                  busy
);
    arb_state_e             state;
    logic [ID_W-1:0]        rr_ptr;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt_n;
    logic [NUM_MASTERS-1:0] rdy_n;
    logic                   cs_n;
    logic                   as_n;
    logic [ADDR_W-1:0]      addr_q;
    logic                   found;
    logic [ID_W-1:0]        win;

    assign req = ~bus.m_req_n;

    // In RESP the owner's req_n is still low during its rdy cycle, so it is
    // kept out of the next pick to avoid an immediate re-grant.
    rr_priority_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_pick (
        .req           (req),
        .ptr           (rr_ptr),
        .exclude_valid (state == ARB_RESP),
        .exclude_id    (owner_id),
        .found         (found),
        .winner_id     (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            gnt_n    <= '1;
            cs_n     <= 1'b1;
            as_n     <= 1'b1;
            addr_q   <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ARB_ADDR: begin
                    cs_n  <= 1'b1;
                    as_n  <= 1'b1;
                    state <= ARB_RESP;
                end
                ARB_IDLE, ARB_RESP: begin
                    // RESP waits indefinitely for the ROM; IDLE decides every cycle.
                    if (state == ARB_IDLE || !bus.rom_rdy_n) begin
                        if (found) begin
                            state    <= ARB_ADDR;
                            gnt_n    <= ~(NUM_MASTERS'(1) << win);
                            owner_id <= win;
                            addr_q   <= bus.m_addr[win];
                            cs_n     <= 1'b0;
                            as_n     <= 1'b0;
                            rr_ptr   <= ID_W'(rr_wrap(int'(win), NUM_MASTERS));
                            busy     <= 1'b1;
                        end else begin
                            state <= ARB_IDLE;
                            gnt_n <= '1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt_n <= '1;
                    cs_n  <= 1'b1;
                    as_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is routed combinationally so the owner sees it in the same cycle
    // the ROM reports it.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_rdy
        assign rdy_n[i] = !(state == ARB_RESP && owner_id == ID_W'(i) && !bus.rom_rdy_n);
    end

    assign bus.m_gnt_n   = gnt_n;
    assign bus.m_rdy_n   = rdy_n;
    assign bus.m_rd_data = bus.rom_rd_data;
    assign bus.rom_cs_n  = cs_n;
    assign bus.rom_as_n  = as_n;
    assign bus.rom_addr  = addr_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
module tb_rom_access_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  owner_id;
    logic        busy;
    int          total  = 0;
    int          passed = 0;
    int          extra_wait = 0;
    logic [10:0] addr_tab [4];

    // ROM model state: registered ready, optional extra wait cycles.
    logic        rom_rdy_q  = 1'b1;
    logic [31:0] rom_data_q = '0;
    logic        pend       = 1'b0;
    int          wcnt       = 0;

    rom_access_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(11), .DATA_W(32)) bus ();

    rom_access_arbiter #(.NUM_MASTERS(4), .ADDR_W(11), .DATA_W(32), .ID_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .owner_id (owner_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [10:0] a);
        return {a, 21'h0} ^ 32'h5A5A_1234 ^ {21'h0, a};
    endfunction

    assign bus.rom_rdy_n   = rom_rdy_q;
    assign bus.rom_rd_data = rom_data_q;

    always @(posedge clk) begin
        if (!bus.rom_cs_n) begin
            pend       <= 1'b1;
            wcnt       <= extra_wait;
            rom_rdy_q  <= (extra_wait == 0) ? 1'b0 : 1'b1;
            rom_data_q <= rom_fn(bus.rom_addr);
        end else if (!rom_rdy_q) begin
            rom_rdy_q <= 1'b1;
            pend      <= 1'b0;
        end else if (pend) begin
            if (wcnt <= 1) rom_rdy_q <= 1'b0;
            wcnt <= wcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] onehot_n(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    initial begin
        int o;
        addr_tab[0] = 11'h000;
        addr_tab[1] = 11'h0AB;
        addr_tab[2] = 11'h2C4;
        addr_tab[3] = 11'h7FF;
        for (int i = 0; i < 4; i++) bus.m_addr[i] = addr_tab[i];
        reset       = 1'b1;
        bus.m_req_n = 4'b0000;

        // Reset held two cycles with everyone requesting.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_gnt_n", bus.m_gnt_n, 4'hF);
            chk("rst_cs_n", bus.rom_cs_n, 1'b1);
            chk("rst_as_n", bus.rom_as_n, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rdy_n", bus.m_rdy_n, 4'hF);
        end
        chk("rst_rom_addr", bus.rom_addr, 11'h0);
        chk("rst_owner", owner_id, 2'd0);
        reset = 1'b0;

        // All four requesting: grants 0,1,2,3,0 with ADDR/RESP alternating.
        for (int k = 0; k < 5; k++) begin
            o = k % 4;
            @(negedge clk);
            chk("rr_owner", owner_id, o);
            chk("rr_gnt_n", bus.m_gnt_n, onehot_n(o));
            chk("rr_cs_n", bus.rom_cs_n, 1'b0);
            chk("rr_as_n", bus.rom_as_n, 1'b0);
            chk("rr_addr", bus.rom_addr, addr_tab[o]);
            chk("rr_busy", busy, 1'b1);
            chk("rr_addr_rdy_n", bus.m_rdy_n, 4'hF);
            @(negedge clk);
            chk("rr_resp_cs_n", bus.rom_cs_n, 1'b1);
            chk("rr_resp_gnt_n", bus.m_gnt_n, onehot_n(o));
            chk("rr_rdy_n", bus.m_rdy_n, onehot_n(o));
            chk("rr_data", bus.m_rd_data, rom_fn(addr_tab[o]));
            if (k == 4) bus.m_req_n = 4'hF;
        end
        @(negedge clk);
        chk("rr_idle_busy", busy, 1'b0);
        chk("rr_idle_gnt_n", bus.m_gnt_n, 4'hF);

        // Single master 1 at 11'h123.
        addr_tab[1] = 11'h123;
        bus.m_addr[1] = 11'h123;
        bus.m_req_n = 4'b1101;
        @(negedge clk);
        chk("m1_cs_n", bus.rom_cs_n, 1'b0);
        chk("m1_as_n", bus.rom_as_n, 1'b0);
        chk("m1_addr", bus.rom_addr, 11'h123);
        chk("m1_gnt_n", bus.m_gnt_n, 4'b1101);
        @(negedge clk);
        chk("m1_rdy_n", bus.m_rdy_n, 4'b1101);
        chk("m1_data", bus.m_rd_data, rom_fn(11'h123));
        bus.m_req_n = 4'hF;
        @(negedge clk);
        chk("m1_idle", busy, 1'b0);

        // Master 2 alone keeps requesting through its rdy cycle.
        bus.m_req_n = 4'b1011;
        @(negedge clk);
        chk("ex_cs1", bus.rom_cs_n, 1'b0);
        chk("ex_owner1", owner_id, 2'd2);
        @(negedge clk);
        chk("ex_rdy1", bus.m_rdy_n, 4'b1011);
        @(negedge clk);
        chk("ex_idle_busy", busy, 1'b0);
        chk("ex_idle_cs", bus.rom_cs_n, 1'b1);
        chk("ex_idle_gnt", bus.m_gnt_n, 4'hF);
        @(negedge clk);
        chk("ex_cs2", bus.rom_cs_n, 1'b0);
        chk("ex_gnt2", bus.m_gnt_n, 4'b1011);
        @(negedge clk);
        chk("ex_rdy2", bus.m_rdy_n, 4'b1011);
        bus.m_req_n = 4'hF;
        @(negedge clk);
        chk("ex_end_busy", busy, 1'b0);

        // Reset while master 3 waits in RESP; the ROM answers after reset.
        extra_wait = 2;
        bus.m_req_n = 4'b0111;
        @(negedge clk);
        chk("rr3_owner", owner_id, 2'd3);
        chk("rr3_cs", bus.rom_cs_n, 1'b0);
        @(negedge clk);
        chk("rr3_wait_rdy", bus.m_rdy_n, 4'hF);
        chk("rr3_wait_gnt", bus.m_gnt_n, 4'b0111);
        reset = 1'b1;
        bus.m_req_n = 4'hF;
        @(negedge clk);
        chk("rr3_rst_gnt", bus.m_gnt_n, 4'hF);
        chk("rr3_rst_busy", busy, 1'b0);
        chk("rr3_rst_rdy", bus.m_rdy_n, 4'hF);
        reset = 1'b0;
        extra_wait = 0;
        @(negedge clk);
        chk("late_rom_rdy", bus.rom_rdy_n, 1'b0);
        chk("late_rdy_ignored", bus.m_rdy_n, 4'hF);
        chk("late_busy", busy, 1'b0);
        chk("late_rr_ptr", dut.rr_ptr, 2'd0);

        // Reset during master 1's ADDR must return the pointer to 0.
        bus.m_req_n = 4'b1101;
        @(negedge clk);
        chk("ra_owner1", owner_id, 2'd1);
        reset = 1'b1;
        bus.m_req_n = 4'b0000;
        @(negedge clk);
        chk("ra_gnt", bus.m_gnt_n, 4'hF);
        chk("ra_rdy_ignored", bus.m_rdy_n, 4'hF);
        reset = 1'b0;
        @(negedge clk);
        chk("ra_owner0", owner_id, 2'd0);
        chk("ra_gnt0", bus.m_gnt_n, 4'b1110);
        @(negedge clk);
        chk("ra_rdy0", bus.m_rdy_n, 4'b1110);
        bus.m_req_n = 4'hF;
        @(negedge clk);
        chk("ra_idle", busy, 1'b0);

        // Slow ROM: three extra not-ready cycles in RESP.
        extra_wait = 3;
        bus.m_req_n = 4'b1110;
        @(negedge clk);
        chk("slow_cs", bus.rom_cs_n, 1'b0);
        chk("slow_owner", owner_id, 2'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("slow_wait_rdy", bus.m_rdy_n, 4'hF);
            chk("slow_wait_gnt", bus.m_gnt_n, 4'b1110);
            chk("slow_wait_busy", busy, 1'b1);
            chk("slow_wait_cs", bus.rom_cs_n, 1'b1);
        end
        @(negedge clk);
        chk("slow_rdy", bus.m_rdy_n, 4'b1110);
        chk("slow_data", bus.m_rd_data, rom_fn(addr_tab[0]));
        bus.m_req_n = 4'hF;
        @(negedge clk);
        chk("slow_rdy_once", bus.m_rdy_n, 4'hF);
        chk("slow_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
